// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Buffers new hex data and commits it only at frame boundaries so a frame never mixes old and new digits.
module seg_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 2,
    parameter int BLANK_LZ = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    input  logic        data_valid,
    output logic [3:0]  hex_out,
    output logic [7:0]  an_n,
    output logic        dp_n,
    output logic        frame_done
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          tick;
    logic          wrap;

    logic [31:0]   pdata;
    logic [7:0]    pdp;
    logic [7:0]    pen;
    logic          pvalid;

    logic [31:0]   ddata;
    logic [7:0]    ddp;
    logic [7:0]    den;

    logic [7:0]    blank;
    logic          zero_run;
    logic          guard_ok;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Prescaler and slot index; every slot lasts SCAN_DIV cycles whether or not its digit lights.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // data_valid is a single-cycle load strobe with no ready: every asserted edge is accepted.
    // On the wrap edge the inputs go straight to the display regs, overriding anything pending.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pdata  <= '0;
            pdp    <= '0;
            pen    <= '1;
            pvalid <= 1'b0;
            ddata  <= '0;
            ddp    <= '0;
            den    <= '1;
        end else if (wrap && data_valid) begin
            ddata  <= data_in;
            ddp    <= dp_in;
            den    <= en_in;
            pvalid <= 1'b0;
        end else if (wrap && pvalid) begin
            ddata  <= pdata;
            ddp    <= pdp;
            den    <= pen;
            pvalid <= 1'b0;
        end else if (data_valid) begin
            pdata  <= data_in;
            pdp    <= dp_in;
            pen    <= en_in;
            pvalid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
        end
    end

    // Walk from the top digit down; a digit is blanked while every nibble from it upward is zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (ddata[4*k +: 4] == 4'h0);
            if (k > 0 && BLANK_LZ != 0) begin
                blank[k] = zero_run;
            end
        end
    end

    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_ok = 1'b1;
        end else begin : g_guard
            assign guard_ok = (cnt >= CW'(GUARD));
        end
    endgenerate

    always_comb begin
        an_n = '1;
        if (guard_ok && den[idx] && !blank[idx]) begin
            an_n[idx] = 1'b0;
        end
    end

    assign hex_out = ddata[{idx, 2'b00} +: 4];
    assign dp_n    = ~ddp[idx] | blank[idx];

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (plain and leading-zero blanking) scanned side by side
// against a frame-level model of what each slot must show.
module tb_seg_scan_ctrl;
    localparam int SD = 4;
    localparam int ND = 8;
    localparam int FR = SD * ND;
    localparam int NV = 11;
    localparam logic [13:0] RST_OUT = {4'h0, 8'hFF, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  en_in;
    logic        data_valid;
    logic [3:0]  hex0, hex1;
    logic [7:0]  an0, an1;
    logic        dpn0, dpn1, fd0, fd1;

    seg_scan_ctrl #(.DIGITS(ND), .SCAN_DIV(SD), .GUARD(1), .BLANK_LZ(0)) dut (
        .clk(clk), .rstn(rstn), .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
        .data_valid(data_valid), .hex_out(hex0), .an_n(an0), .dp_n(dpn0), .frame_done(fd0)
    );

    seg_scan_ctrl #(.DIGITS(ND), .SCAN_DIV(SD), .GUARD(1), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .rstn(rstn), .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
        .data_valid(data_valid), .hex_out(hex1), .an_n(an1), .dp_n(dpn1), .frame_done(fd1)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  en;
        int          frame;
        int          at;
    } vec_t;

    vec_t        vecs[NV];
    logic [27:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          t = 0;
    int          last_fd = -1;
    logic [31:0] sh_data, ld_data;
    logic [7:0]  sh_dp, sh_en, ld_dp, ld_en;
    bit          ld_v;

    // Expected {hex, an_n, dp_n, frame_done} at t cycles after reset release, given the frame's data.
    function automatic logic [13:0] model(input int tt, input logic [31:0] d, input logic [7:0] p,
                                          input logic [7:0] e, input bit lz);
        int k;
        logic [3:0] h;
        logic [7:0] a;
        logic bl, dn, fd;
        k  = (tt / SD) % ND;
        h  = d[4*k +: 4];
        bl = lz && (k > 0) && ((d >> (4*k)) == 32'd0);
        a  = 8'hFF;
        if ((tt % SD) >= 1 && e[k] && !bl) a[k] = 1'b0;
        dn = ~p[k] | bl;
        fd = (tt % FR == 0) && (tt > 0);
        return {h, a, dn, fd};
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got hex=%h an_n=%h dp_n=%b fd=%b exp hex=%h an_n=%h dp_n=%b fd=%b",
                     name, t, got[13:10], got[9:2], got[1], got[0],
                     exp[13:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic model_reset();
        sh_data = 32'h0;
        sh_dp   = 8'h00;
        sh_en   = 8'hFF;
        ld_v    = 1'b0;
        t       = 0;
        last_fd = -1;
        exp_q.delete();
    endtask

    task automatic push_exp();
        exp_q.push_back({model(t, sh_data, sh_dp, sh_en, 1'b0), model(t, sh_data, sh_dp, sh_en, 1'b1)});
    endtask

    // scoreboard: pop one expectation per sampled cycle
    task automatic score();
        logic [27:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0d got 0 entries need 1", t);
        end else begin
            e = exp_q.pop_front();
            check("scan", {hex0, an0, dpn0, fd0}, e[27:14]);
            check("scan_lz", {hex1, an1, dpn1, fd1}, e[13:0]);
            if (fd0) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (t - last_fd != FR) begin
                        errors++;
                        $display("FAIL frame_period got %0d cycles need %0d", t - last_fd, FR);
                    end
                end
                last_fd = t;
            end
        end
    endtask

    // driver: called at a negedge, drives the next posedge and checks the following negedge
    task automatic cycle(input bit ld, input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
        data_in    = d;
        dp_in      = p;
        en_in      = e;
        data_valid = ld;
        if (ld) begin
            ld_v    = 1'b1;
            ld_data = d;
            ld_dp   = p;
            ld_en   = e;
        end
        t++;
        if (t % FR == 0 && ld_v) begin
            sh_data = ld_data;
            sh_dp   = ld_dp;
            sh_en   = ld_en;
            ld_v    = 1'b0;
        end
        push_exp();
        @(negedge clk);
        data_valid = 1'b0;
        score();
    endtask

    task automatic idle();
        cycle(1'b0, $urandom(), 8'($urandom()), 8'($urandom()));
    endtask

    initial begin
        rstn       = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        dp_in      = '0;
        en_in      = '0;

        vecs[0]  = '{32'h1234_ABCD, 8'h01, 8'hFF, 0, 5};
        vecs[1]  = '{32'h1111_1111, 8'h00, 8'hFF, 1, 12};
        vecs[2]  = '{32'h2222_2222, 8'h80, 8'hFF, 1, 20};
        vecs[3]  = '{32'h8765_4321, 8'h10, 8'hFF, 2, 31};
        vecs[4]  = '{32'hAAAA_AAAA, 8'h55, 8'hFF, 3, 10};
        vecs[5]  = '{32'h0F0F_0F0F, 8'hFF, 8'h0F, 3, 31};
        vecs[6]  = '{32'h0000_0050, 8'h00, 8'hFF, 5, 3};
        vecs[7]  = '{32'h0000_0000, 8'hFF, 8'hFF, 6, 7};
        vecs[8]  = '{32'h1000_0000, 8'h02, 8'hFF, 7, 0};
        vecs[9]  = '{$urandom(), 8'($urandom()), 8'($urandom()), 8, 16};
        vecs[10] = '{$urandom(), 8'($urandom()), 8'hFF, 9, 30};

        model_reset();
        repeat (3) @(negedge clk);
        check("rst", {hex0, an0, dpn0, fd0}, RST_OUT);
        check("rst_lz", {hex1, an1, dpn1, fd1}, RST_OUT);
        rstn = 1'b1;
        push_exp();
        score();

        for (int i = 0; i < NV; i++) begin
            while (t < vecs[i].frame * FR + vecs[i].at) idle();
            cycle(1'b1, vecs[i].data, vecs[i].dp, vecs[i].en);
        end
        while (t < 11 * FR) idle();

        // Reset in slot 5 with a load pending: outputs drop at once and the load never shows.
        while (t < 11 * FR + 12) idle();
        cycle(1'b1, 32'hDEAD_BEEF, 8'hFF, 8'hFF);
        while (t < 11 * FR + 21) idle();
        rstn = 1'b0;
        #1;
        check("rst_async", {hex0, an0, dpn0, fd0}, RST_OUT);
        check("rst_async_lz", {hex1, an1, dpn1, fd1}, RST_OUT);
        model_reset();
        @(negedge clk);
        check("rst_hold", {hex0, an0, dpn0, fd0}, RST_OUT);
        check("rst_hold_lz", {hex1, an1, dpn1, fd1}, RST_OUT);
        rstn = 1'b1;
        push_exp();
        score();
        repeat (2 * FR + 1) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
